// File: rtl/sccb_config_sequencer.sv
// OV7670 boot sequencer: replays a {register, value} table over a 3-phase SCCB
// write bus after power-up, then flags DONE so capture can be enabled.
module sccb_config_sequencer #(
    parameter int         CLK_DIV     = 125,
    parameter int         NUM_REGS    = 32,
    parameter logic [7:0] DEV_ADDR    = 8'h42,
    parameter int         PWRUP_TICKS = 4000,
    parameter int         GAP_TICKS   = 8,
    localparam int        AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          START,
    output logic [AW-1:0] ROM_ADDR,
    input  logic [15:0]   ROM_DATA,
    output logic          SIOC,
    output logic          SIOD_OUT,
    output logic          SIOD_OE,
    output logic          BUSY,
    output logic          DONE,
    output logic [5:0]    TX_COUNT
);

    // The index needs one value beyond the table so it can saturate at NUM_REGS.
    localparam int IW      = $clog2(NUM_REGS + 1);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (PWRUP_TICKS > GAP_TICKS) ? PWRUP_TICKS : GAP_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 4);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_LOAD,
        S_STRT,
        S_BITS,
        S_STOP,
        S_GAP,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [1:0]    ph_q, ph_d;
    logic [26:0]   shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [5:0]    tx_q, tx_d;
    logic          sioc_q, sioc_d;
    logic          sdo_q, sdo_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pend_q, pend_d;
    logic          tick_s;
    logic          ack_s;

    // Free-running quarter-bit divider.
    always_comb begin
        tick_s = (div_q == DW'(CLK_DIV - 1));
        if (tick_s) begin
            div_d = {DW{1'b0}};
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // START is only honoured while idle; it is held until the idle state consumes it.
    always_comb begin
        pend_d = pend_q;
        if (tick_s && (state_q == S_IDLE)) begin
            pend_d = 1'b0;
        end else if (START && !busy_q) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    assign ack_s = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

    // Sequencer: next state and next bus/status values, evaluated on ticks only.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        sioc_d  = sioc_q;
        sdo_d   = sdo_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (tick_s) begin
            case (state_q)
                S_PWRUP: begin
                    busy_d = 1'b1;
                    if (cnt_q == CW'(PWRUP_TICKS - 1)) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (pend_q || START) begin
                        done_d  = 1'b0;
                        tx_d    = 6'd0;
                        idx_d   = {IW{1'b0}};
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                // The start condition is launched on the same tick the entry is latched.
                S_LOAD: begin
                    if ((ROM_DATA == 16'hFFFF) || (idx_q == IW'(NUM_REGS))) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end else begin
                        shift_d = {DEV_ADDR, 1'b1, ROM_DATA[15:8], 1'b1, ROM_DATA[7:0], 1'b1};
                        oe_d    = 1'b1;
                        sdo_d   = 1'b0;
                        sioc_d  = 1'b1;
                        state_d = S_STRT;
                    end
                end
                S_STRT: begin
                    sioc_d  = 1'b0;
                    bit_d   = 5'd0;
                    ph_d    = 2'd0;
                    state_d = S_BITS;
                end
                S_BITS: begin
                    ph_d = ph_q + 2'd1;
                    case (ph_q)
                        2'd0: begin
                            sdo_d  = shift_q[26];
                            oe_d   = !ack_s;
                            sioc_d = 1'b0;
                        end
                        2'd1: begin
                            sioc_d = 1'b0;
                        end
                        2'd2: begin
                            sioc_d = 1'b1;
                        end
                        2'd3: begin
                            sioc_d  = 1'b1;
                            shift_d = {shift_q[25:0], 1'b1};
                            if (bit_q == 5'd26) begin
                                cnt_d   = {CW{1'b0}};
                                state_d = S_STOP;
                            end else begin
                                bit_d = bit_q + 5'd1;
                            end
                        end
                        default: begin
                            sioc_d = 1'b1;
                        end
                    endcase
                end
                S_STOP: begin
                    if (cnt_q == CW'(0)) begin
                        oe_d   = 1'b1;
                        sdo_d  = 1'b0;
                        sioc_d = 1'b0;
                        cnt_d  = cnt_q + CW'(1);
                    end else if (cnt_q == CW'(1)) begin
                        sioc_d = 1'b1;
                        cnt_d  = cnt_q + CW'(1);
                    end else begin
                        sdo_d   = 1'b1;
                        oe_d    = 1'b0;
                        cnt_d   = {CW{1'b0}};
                        tx_d    = (tx_q == 6'd63) ? tx_q : tx_q + 6'd1;
                        idx_d   = (idx_q == IW'(NUM_REGS)) ? idx_q : idx_q + IW'(1);
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q == CW'(GAP_TICKS - 1)) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_FIN: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    sioc_d  = 1'b1;
                    sdo_d   = 1'b1;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; reset forces the bus idle-high at once.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_PWRUP;
            div_q   <= {DW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 5'd0;
            ph_q    <= 2'd0;
            shift_q <= {27{1'b1}};
            idx_q   <= {IW{1'b0}};
            tx_q    <= 6'd0;
            sioc_q  <= 1'b1;
            sdo_q   <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            sioc_q  <= sioc_d;
            sdo_q   <= sdo_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign ROM_ADDR = idx_q[AW-1:0];
    assign SIOC     = sioc_q;
    assign SIOD_OUT = sdo_q;
    assign SIOD_OE  = oe_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign TX_COUNT = tx_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench: decodes the SCCB bus of a 32-entry instance and checks a
// 3-entry instance that has no terminator in its table.
module tb_sccb_config_sequencer;

    localparam int TB_DIV = 2;

    logic        CLOCK;
    logic        RESET;
    logic        START;
    logic [4:0]  rom_addr_a;
    logic [15:0] rom_data_a;
    logic        sioc_a, siod_a, oe_a, busy_a, done_a;
    logic [5:0]  tx_a;
    logic [1:0]  rom_addr_b;
    logic [15:0] rom_data_b;
    logic        sioc_b, siod_b, oe_b, busy_b, done_b;
    logic [5:0]  tx_b;
    logic        term0;

    int n_cmp = 0;
    int n_bad = 0;

    sccb_config_sequencer #(.CLK_DIV(TB_DIV), .NUM_REGS(32), .DEV_ADDR(8'h42),
                            .PWRUP_TICKS(4), .GAP_TICKS(8)) u_dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .START(START),
        .ROM_ADDR(rom_addr_a), .ROM_DATA(rom_data_a),
        .SIOC(sioc_a), .SIOD_OUT(siod_a), .SIOD_OE(oe_a),
        .BUSY(busy_a), .DONE(done_a), .TX_COUNT(tx_a)
    );

    sccb_config_sequencer #(.CLK_DIV(TB_DIV), .NUM_REGS(3), .DEV_ADDR(8'h42),
                            .PWRUP_TICKS(4), .GAP_TICKS(8)) u_dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .START(1'b0),
        .ROM_ADDR(rom_addr_b), .ROM_DATA(rom_data_b),
        .SIOC(sioc_b), .SIOD_OUT(siod_b), .SIOD_OE(oe_b),
        .BUSY(busy_b), .DONE(done_b), .TX_COUNT(tx_b)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Table ROMs: A = two entries then terminator, B = never terminates.
    always_comb begin
        if (term0) begin
            rom_data_a = 16'hFFFF;
        end else begin
            case (rom_addr_a)
                5'd0:    rom_data_a = 16'h1280;
                5'd1:    rom_data_a = 16'h1101;
                default: rom_data_a = 16'hFFFF;
            endcase
        end
        rom_data_b = 16'h30A0 | {6'b0, rom_addr_b, 6'b0, rom_addr_b};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Posedges since reset release; tick n lands on posedge n*TB_DIV.
    int pcnt = 0;
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) pcnt <= 0;
        else        pcnt <= pcnt + 1;
    end

    // Bus decoder for instance A, sampled on the falling clock edge.
    logic [26:0] frame [0:15];
    int          start_tk [0:15];
    int          stop_tk [0:15];
    int          nfr = 0;
    int          bitn = 0;
    int          oe_err = 0;
    int          proto_err = 0;
    int          act_cnt = 0;
    logic        in_tx = 1'b0;
    logic [26:0] sh;
    logic        line, p_line, p_sioc, p_oe, p_sdo, p_rst;

    initial begin
        p_line = 1'b1; p_sioc = 1'b1; p_oe = 1'b0; p_sdo = 1'b1; p_rst = 1'b0;
        sh = '0;
        forever begin
            @(negedge CLOCK);
            line = oe_a ? siod_a : 1'b1;
            if (!RESET) begin
                in_tx = 1'b0;
                bitn  = 0;
            end else begin
                if (p_rst && ((sioc_a != p_sioc) || (siod_a != p_sdo) || (oe_a != p_oe)))
                    act_cnt++;
                if (p_sioc && sioc_a && p_line && !line) begin
                    if (in_tx) proto_err++;
                    in_tx = 1'b1;
                    bitn  = 0;
                    sh    = '0;
                    if (nfr < 16) start_tk[nfr] = pcnt / TB_DIV;
                end else if (p_sioc && sioc_a && !p_line && line) begin
                    if (!in_tx || bitn != 27) proto_err++;
                    if (nfr < 16) begin
                        stop_tk[nfr] = pcnt / TB_DIV;
                        frame[nfr]   = sh;
                        nfr++;
                    end
                    in_tx = 1'b0;
                end else if (!p_sioc && sioc_a && in_tx && bitn < 27) begin
                    sh = {sh[25:0], line};
                    if (oe_a != !(bitn == 8 || bitn == 17 || bitn == 26)) oe_err++;
                    bitn++;
                end else if (in_tx && !sioc_a && bitn < 27) begin
                    if (oe_a != !(bitn == 8 || bitn == 17 || bitn == 26)) oe_err++;
                end
            end
            p_sioc = sioc_a; p_line = line; p_oe = oe_a; p_sdo = siod_a; p_rst = RESET;
        end
    end

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLOCK);
            if (done_a) break;
        end
        chk(tag, {31'b0, done_a}, 32'd1);
    endtask

    task automatic chk_frame(input int k, input logic [7:0] r, input logic [7:0] v);
        chk($sformatf("frame%0d_dev", k), {24'b0, frame[k][26:19]}, 32'h42);
        chk($sformatf("frame%0d_reg", k), {24'b0, frame[k][17:10]}, {24'b0, r});
        chk($sformatf("frame%0d_val", k), {24'b0, frame[k][8:1]}, {24'b0, v});
    endtask

    task automatic release_reset();
        @(negedge CLOCK);
        #2 RESET = 1'b1;
    endtask

    int base;

    initial begin
        RESET = 1'b0;
        START = 1'b0;
        term0 = 1'b0;
        #22;
        chk("rst_sioc", {31'b0, sioc_a}, 32'd1);
        chk("rst_siod", {31'b0, siod_a}, 32'd1);
        chk("rst_oe",   {31'b0, oe_a},   32'd0);
        chk("rst_addr", {27'b0, rom_addr_a}, 32'd0);
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_done", {31'b0, done_a}, 32'd0);
        chk("rst_tx",   {26'b0, tx_a},   32'd0);

        // Power-up boot of both instances.
        release_reset();
        wait_done_a("boot_done_a");
        chk("boot_nfr",   nfr, 32'd2);
        chk("boot_start0_tick", start_tk[0], 32'd5);
        chk("boot_stop0_tick",  stop_tk[0],  32'd117);
        chk("boot_start1_tick", start_tk[1], 32'd126);
        chk_frame(0, 8'h12, 8'h80);
        chk_frame(1, 8'h11, 8'h01);
        chk("boot_tx",   {26'b0, tx_a}, 32'd2);
        chk("boot_addr", {27'b0, rom_addr_a}, 32'd2);
        chk("boot_busy", {31'b0, busy_a}, 32'd0);
        for (int i = 0; i < 3000; i++) begin
            if (done_b) break;
            @(negedge CLOCK);
        end
        chk("b_done", {31'b0, done_b}, 32'd1);
        chk("b_tx",   {26'b0, tx_b}, 32'd3);
        chk("b_addr", {30'b0, rom_addr_b}, 32'd3);

        // Restart by START; a second START mid-run must be ignored.
        repeat (10) @(negedge CLOCK);
        base = nfr;
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        @(negedge CLOCK);
        chk("restart_done", {31'b0, done_a}, 32'd0);
        chk("restart_tx",   {26'b0, tx_a}, 32'd0);
        chk("restart_busy", {31'b0, busy_a}, 32'd1);
        repeat (60) @(negedge CLOCK);
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        wait_done_a("restart_done_end");
        chk("restart_nfr", nfr - base, 32'd2);
        chk("restart_tx_end", {26'b0, tx_a}, 32'd2);
        chk_frame(base, 8'h12, 8'h80);
        chk_frame(base + 1, 8'h11, 8'h01);

        // Reset in the middle of the second transaction's data bits.
        repeat (10) @(negedge CLOCK);
        base = nfr;
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLOCK);
            if (nfr == base + 1 && in_tx && bitn >= 5) break;
        end
        chk("abort_reached", {31'b0, in_tx}, 32'd1);
        #2 RESET = 1'b0;
        #1;
        chk("abort_sioc", {31'b0, sioc_a}, 32'd1);
        chk("abort_oe",   {31'b0, oe_a},   32'd0);
        chk("abort_busy", {31'b0, busy_a}, 32'd0);
        chk("abort_done", {31'b0, done_a}, 32'd0);
        repeat (3) @(negedge CLOCK);
        base = nfr;
        release_reset();
        wait_done_a("reboot_done");
        chk("reboot_nfr", nfr - base, 32'd2);
        chk("reboot_start_tick", start_tk[base], 32'd5);
        chk_frame(base, 8'h12, 8'h80);
        chk_frame(base + 1, 8'h11, 8'h01);
        chk("reboot_tx", {26'b0, tx_a}, 32'd2);

        // Terminator at index 0: DONE one tick after power-up, bus untouched.
        @(negedge CLOCK);
        RESET = 1'b0;
        term0 = 1'b1;
        repeat (3) @(negedge CLOCK);
        release_reset();
        base = act_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK);
            if (pcnt == 9) break;
        end
        chk("term_done_t4", {31'b0, done_a}, 32'd0);
        @(negedge CLOCK);
        chk("term_pcnt", pcnt, 32'd10);
        chk("term_done_t5", {31'b0, done_a}, 32'd1);
        chk("term_tx", {26'b0, tx_a}, 32'd0);
        repeat (20) @(negedge CLOCK);
        chk("term_activity", act_cnt - base, 32'd0);
        chk("term_busy", {31'b0, busy_a}, 32'd0);

        chk("oe_errors", oe_err, 32'd0);
        chk("protocol_errors", proto_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
